divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter TAG_W, default 4, width of the result-broadcast tag carried with each operation.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  issue request carrying an operation.
REQ-005 in_ready  output  1  unit able to accept an operation this cycle.
REQ-006 Vj  input  32  dividend (rs1 value).
REQ-007 Vk  input  32  divisor (rs2 value).
REQ-008 Op  input  10  operation code; Op[8:7] selects DIV=00, DIVU=01, REM=10, REMU=11; other bits ignored.
REQ-009 tag_in  input  TAG_W  destination tag of the issued operation.
REQ-010 flush  input  1  synchronous abort of any in-flight operation.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  result consumer accepts this cycle.
REQ-013 y  output  32  quotient or remainder.
REQ-014 tag_out  output  TAG_W  tag of the operation producing y.

Function
REQ-015 States IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Accept on in_valid&&in_ready: latch |Vj|, |Vk| (signed ops) or raw values (unsigned ops), Op[8:7], tag_in, result sign flags; go BUSY with iteration count 0.
REQ-017 BUSY: one restoring-division step per cycle, MSB first, 32-bit partial remainder plus 1 guard bit; after the 32nd step go DONE.
REQ-018 Latency: out_valid high in the 32nd cycle after the acceptance edge (33rd edge samples it).
REQ-019 DONE: y and tag_out held stable until out_valid&&out_ready, then IDLE next edge; no new acceptance while DONE.
REQ-020 Signed ops: quotient negated iff sign(Vj)!=sign(Vk); remainder takes sign of Vj; all arithmetic modulo 2^32.
REQ-021 Divisor zero: DIV/DIVU y=0xFFFFFFFF; REM/REMU y=Vj.
REQ-022 Signed overflow (Vj=0x80000000, Vk=0xFFFFFFFF): DIV y=0x80000000; REM y=0.
REQ-023 flush has priority over all events: next state IDLE, result discarded, out_valid low next cycle; flush coinciding with acceptance drops that operation.
REQ-024 y and tag_out are don't-care but stable when out_valid is low.

Reset
REQ-025 rst_n low: state IDLE, out_valid=0, in_ready=1 after release, y=0, tag_out=0, counter and datapath registers 0, immediately and regardless of clk.
REQ-026 Reset mid-operation abandons it without producing out_valid.

Configuration
REQ-027 Macro DIVIDER_EARLY_OUT_EN defined: divide-by-zero and signed-overflow cases go IDLE->DONE at acceptance edge (out_valid next cycle, latency 1).
REQ-028 Macro undefined: every operation takes full 32-step latency; results per REQ-021/022 unchanged.

Structure
REQ-029 Shared package div_pkg holds the div_op_t enum (DIV, DIVU, REM, REMU), the div_state_t enum, and constant DIV_STEPS=32.
REQ-030 Sub-module divider_step: combinational single restoring iteration (remainder in, divisor, next dividend bit -> remainder out, quotient bit); instantiated once.

Verification
REQ-031 DIV Vj=-7 (0xFFFFFFF9), Vk=2 -> y=0xFFFFFFFD (-3) with out_valid in 32nd cycle; REM same operands -> y=0xFFFFFFFF (-1).
REQ-032 DIVU Vj=0xFFFFFFFF, Vk=0x10 -> y=0x0FFFFFFF; REMU -> y=0xF.
REQ-033 DIV Vj=5, Vk=0 -> 0xFFFFFFFF; REM Vj=5, Vk=0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; latency 1 with DIVIDER_EARLY_OUT_EN, 32 without.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> y, tag_out stable, in_ready=0; in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
REQ-035 Assert flush at iteration 15 -> no out_valid; next op DIVU 100/7 with tag 3 -> y=14, tag_out=3.
REQ-036 Drop rst_n asynchronously mid-BUSY -> out_valid=0, y=0 before next clk edge; in_ready=1 after release.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam int DIV_STEPS = 32;

    function automatic logic [31:0] neg_if(input logic [31:0] v,
                                           input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
module divider_step (
    input  logic [32:0] rem_in,
    input  logic [31:0] dvs,
    input  logic        bit_in,
    output logic [32:0] rem_out,
    output logic        q
);

    logic [33:0] sh;
    logic [33:0] diff;

    always_comb begin
        sh      = {rem_in, bit_in};
        diff    = sh - {2'b00, dvs};
        q       = ~diff[33];
        rem_out = q ? diff[32:0] : sh[32:0];
    end

endmodule

// File: rtl/divider.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU) with tag broadcast.
// Optional DIVIDER_EARLY_OUT_EN: divide-by-zero and overflow finish at accept.
module divider #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Vj,
    input  logic [31:0]      Vk,
    input  logic [9:0]       Op,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] tag_out
);

    import div_pkg::*;

    div_state_t       state, state_n;
    logic [4:0]       cnt;
    logic [31:0]      dvd, dvs;
    logic [32:0]      rem;
    div_op_t          op;
    logic [TAG_W-1:0] tag;
    logic             qneg, rneg, dz;

    logic             accept, last;
    div_op_t          op_in;
    logic             sgn_in, a_neg, b_neg, dz_in;
    logic [31:0]      a_abs, b_abs;
    logic             early;
    logic [31:0]      early_y;
    logic [32:0]      st_rem, st_rem_o;
    logic [31:0]      st_dvs;
    logic             st_bit, st_q;
    logic [31:0]      q_fin, r_fin, res;
    logic             unused_op;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == 5'(DIV_STEPS - 2));
    assign unused_op = ^{Op[9], Op[6:0]};

    assign op_in  = div_op_t'(Op[8:7]);
    assign sgn_in = ~Op[7];
    assign a_neg  = sgn_in & Vj[31];
    assign b_neg  = sgn_in & Vk[31];
    assign a_abs  = neg_if(Vj, a_neg);
    assign b_abs  = neg_if(Vk, b_neg);
    assign dz_in  = (Vk == 32'd0);

`ifdef DIVIDER_EARLY_OUT_EN
    logic ovf_in;
    assign ovf_in  = sgn_in && (Vj == 32'h8000_0000)
                     && (Vk == 32'hFFFF_FFFF);
    assign early   = dz_in | ovf_in;
    assign early_y = dz_in ? (op_in[1] ? Vj : 32'hFFFF_FFFF)
                           : (op_in[1] ? 32'h0 : 32'h8000_0000);
`else
    assign early   = 1'b0;
    assign early_y = 32'h0;
`endif

    // First iteration runs on the accepting edge straight from the operands
    assign st_rem = (state == BUSY) ? rem     : 33'd0;
    assign st_dvs = (state == BUSY) ? dvs     : b_abs;
    assign st_bit = (state == BUSY) ? dvd[31] : a_abs[31];

    divider_step u_step (
        .rem_in  (st_rem),
        .dvs     (st_dvs),
        .bit_in  (st_bit),
        .rem_out (st_rem_o),
        .q       (st_q)
    );

    always_comb begin
        q_fin = {dvd[30:0], st_q};
        r_fin = st_rem_o[31:0];
        if (op == REM || op == REMU)
            res = neg_if(r_fin, rneg);
        else if (dz && op == DIV)
            res = 32'hFFFF_FFFF;
        else
            res = neg_if(q_fin, qneg);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = early ? DONE : BUSY;
            BUSY: if (last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            op      <= DIV;
            tag     <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            dz      <= 1'b0;
            y       <= '0;
            tag_out <= '0;
        end else if (!flush) begin
            if (accept) begin
                cnt  <= '0;
                dvd  <= {a_abs[30:0], st_q};
                dvs  <= b_abs;
                rem  <= st_rem_o;
                op   <= op_in;
                tag  <= tag_in;
                qneg <= a_neg ^ b_neg;
                rneg <= a_neg;
                dz   <= dz_in;
                if (early) begin
                    y       <= early_y;
                    tag_out <= tag_in;
                end
            end else if (state == BUSY) begin
                cnt <= cnt + 5'd1;
                dvd <= q_fin;
                rem <= st_rem_o;
                if (last) begin
                    y       <= res;
                    tag_out <= tag;
                end
            end
        end
    end

endmodule
